// File: rtl/memory_dump_controller_pkg.sv
// Shared encodings and sizing helpers for the data-memory dump path.
// Imported by memory_dump_controller and word_serializer.
package memory_dump_pkg;

  localparam int NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_NB      = 32;
  localparam int DEF_TAM     = 16;
  localparam int DEF_NB_BYTE = 8;

  localparam int BYTES_PER_WORD = DEF_NB / DEF_NB_BYTE;
  localparam int NB_WORD_IDX    = $clog2(DEF_TAM);
  localparam int NB_BYTE_IDX    = $clog2(BYTES_PER_WORD);

  // Counter width that stays legal when only one item exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_dump_controller_word_serializer.sv
// Holds one memory word and streams it out LSB byte first.
// Ports: i_load/i_word capture, i_send/i_tx_ready handshake, o_last_accept.
module word_serializer
  import memory_dump_pkg::*;
#(
  parameter int NB      = DEF_NB,
  parameter int NB_BYTE = DEF_NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB-1:0]      i_word,
  input  logic               i_send,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_last_accept
);

  localparam int BPW     = NB / NB_BYTE;
  localparam int NB_BIDX = idx_w(BPW);
  localparam logic [NB_BIDX-1:0] LAST_BYTE =
    NB_BIDX'(BPW - 1);

  logic [NB-1:0]      word_q;
  logic [NB_BIDX-1:0] byte_idx_q;
  logic [NB-1:0]      shifted;
  logic               accept;
  logic               last;

  assign accept  = i_send & i_tx_ready;
  assign last    = (byte_idx_q == LAST_BYTE);
  assign shifted = word_q >> (32'(byte_idx_q) * NB_BYTE);

  assign o_tx_valid    = i_send;
  assign o_last_accept = accept & last;
  assign o_tx_data     = i_send ? shifted[NB_BYTE-1:0] : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else if (i_load) begin
      word_q     <= i_word;
      byte_idx_q <= '0;
    end else if (accept) begin
      byte_idx_q <= last ? '0 : byte_idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/memory_dump_controller.sv
// Walks data memory through the debug port and streams it to debug TX.
// Ports: i_start/i_pipeline_halted request, debug addr/data, TX handshake.
module memory_dump_controller
  import memory_dump_pkg::*;
#(
  parameter int NB          = DEF_NB,
  parameter int TAM         = DEF_TAM,
  parameter int NB_BYTE     = DEF_NB_BYTE,
  parameter int ADDR_STRIDE = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_pipeline_halted,
  input  logic [NB-1:0]      i_debug_data,
  input  logic               i_tx_ready,
  output logic [NB-1:0]      o_debug_address,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_IDX = idx_w(TAM);
  localparam logic [NB_IDX-1:0] LAST_WORD =
    NB_IDX'(TAM - 1);

  state_t            state_q;
  state_t            state_d;
  logic [NB_IDX-1:0] word_idx_q;
  logic              clr_idx;
  logic              inc_idx;
  logic              addr_en;
  logic              load;
  logic              send;
  logic              last_acc;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr_idx)
        word_idx_q <= '0;
      else if (inc_idx)
        word_idx_q <= word_idx_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_idx = 1'b0;
    inc_idx = 1'b0;
    addr_en = 1'b0;
    load    = 1'b0;
    send    = 1'b0;
    o_busy  = 1'b1;
    o_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start && i_pipeline_halted) begin
          state_d = ADDR;
          clr_idx = 1'b1;
        end
      end
      ADDR: begin
        addr_en = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // read data lands one cycle after the address
        addr_en = 1'b1;
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        addr_en = 1'b1;
        send    = 1'b1;
        if (last_acc) begin
          if (word_idx_q == LAST_WORD) begin
            state_d = DONE;
          end else begin
            inc_idx = 1'b1;
            state_d = ADDR;
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        o_busy  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_debug_address = addr_en
    ? NB'(word_idx_q) * NB'(ADDR_STRIDE)
    : '0;

  word_serializer #(
    .NB      (NB),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_load        (load),
    .i_word        (i_debug_data),
    .i_send        (send),
    .i_tx_ready    (i_tx_ready),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .o_last_accept (last_acc)
  );

endmodule
